// File: rtl/ahb_sram_slave.sv
//------------------------------------------------------------------------------
// ahb_sram_slave
//
// AHB-Lite responder in front of a single-port 32-bit word SRAM. It is the
// default memory target behind the EVA AHB master. Each beat is decoded on its
// own (hburst/hprot are not used). The slave serves word reads and writes that
// fall inside [ADDR_BASE, ADDR_BASE + 4*MEM_DEPTH), and inserts WAIT_CYCLES
// wait states before every OKAY data phase. Any other accepted transfer gets a
// two-cycle ERROR response and leaves the memory untouched.
//
// Parameters:
//   ADDR_BASE    byte base address of the window
//   MEM_DEPTH    number of 32-bit words
//   WAIT_CYCLES  wait states per OKAY data phase (0..15)
//
// Ports:
//   hclk        bus clock
//   hrest       synchronous active-high reset
//   hsel        slave select
//   htrans      IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
//   hwrite      1 = write
//   haddr       byte address (address phase)
//   hwdata      write data (data phase)
//   hsize       transfer size, only 3'b010 (word) is legal
//   hburst      unused
//   hprot       unused
//   hready_in   bus-level HREADY; address phases only count when it is high
//   hready_out  slave HREADY
//   hresp       OKAY=00, ERROR=01
//   hrdata      read data; zero outside read data cycles
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module ahb_sram_slave #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          MEM_DEPTH   = 1024,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        hclk,
    input  logic        hrest,
    input  logic        hsel,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic        hready_in,
    output logic        hready_out,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata
);

    localparam int          IDX_W        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [32:0] WINDOW_BYTES = 33'(MEM_DEPTH) * 33'd4;
    localparam logic [3:0]  WAIT_LOAD    = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [1:0]  RESP_ERROR   = 2'b01;
    localparam logic [2:0]  SIZE_WORD    = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t state;
    state_t next_state;

    logic [31:0]      mem [MEM_DEPTH];

    logic             is_write;
    logic             next_is_write;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] next_idx;
    logic [3:0]       wait_cnt;
    logic [3:0]       next_wait_cnt;
    logic [31:0]      rd_buf;
    logic [31:0]      next_rd_buf;

    logic [31:0]      offset;
    logic             in_window;
    logic             legal;
    logic             accept;
    logic             take_addr;
    logic             mem_we;
    logic [IDX_W-1:0] addr_idx;
    logic             unused_inputs;

    // Address decode. The subtraction wraps for addresses below the base,
    // which turns them into huge offsets and so fails the window test.
    assign offset    = haddr - ADDR_BASE;
    assign in_window = ({1'b0, offset} < WINDOW_BYTES);
    assign legal     = in_window && (haddr[1:0] == 2'b00) && (hsize == SIZE_WORD);
    assign addr_idx  = offset[IDX_W+1:2];
    assign accept    = hsel && htrans[1] && hready_in;

    assign unused_inputs = ^{hburst, hprot, htrans[0]};

    // State register.
    always_ff @(posedge hclk) begin
        if (hrest) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Data-phase context: direction, word index, wait counter and the read
    // word that will be presented in the coming read data cycle.
    always_ff @(posedge hclk) begin
        if (hrest) begin
            is_write <= 1'b0;
            idx      <= '0;
            wait_cnt <= 4'd0;
            rd_buf   <= 32'd0;
        end else begin
            is_write <= next_is_write;
            idx      <= next_idx;
            wait_cnt <= next_wait_cnt;
            rd_buf   <= next_rd_buf;
        end
    end

    // Write port. A reset in the same cycle drops the pending write.
    assign mem_we = (state == ST_DATA) && is_write && !hrest;

    always_ff @(posedge hclk) begin
        if (mem_we) begin
            mem[idx] <= hwdata;
        end
    end

    // Next-state logic and bus response. IDLE, DATA and ERR2 all drive
    // hready_out high, so they are the only states that can take a new
    // address phase.
    always_comb begin
        next_state    = state;
        next_is_write = is_write;
        next_idx      = idx;
        next_wait_cnt = wait_cnt;
        next_rd_buf   = rd_buf;
        hready_out    = 1'b1;
        hresp         = RESP_OKAY;
        take_addr     = 1'b0;

        case (state)
            ST_IDLE, ST_DATA: begin
                next_state = ST_IDLE;
                take_addr  = accept;
            end
            ST_WAIT: begin
                hready_out = 1'b0;
                if (wait_cnt == 4'd0) begin
                    next_state = ST_DATA;
                end else begin
                    next_wait_cnt = wait_cnt - 4'd1;
                end
            end
            ST_ERR1: begin
                hready_out = 1'b0;
                hresp      = RESP_ERROR;
                next_state = ST_ERR2;
            end
            ST_ERR2: begin
                hresp      = RESP_ERROR;
                next_state = ST_IDLE;
                take_addr  = accept;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        if (take_addr) begin
            next_is_write = hwrite;
            next_idx      = addr_idx;
            if (!legal) begin
                next_state = ST_ERR1;
            end else if (WAIT_CYCLES > 0) begin
                next_state    = ST_WAIT;
                next_wait_cnt = WAIT_LOAD;
            end else begin
                next_state = ST_DATA;
            end
        end

        // The read word is fetched on the edge that enters DATA. If a write
        // to the same word is finishing in this very cycle, the memory still
        // holds the old value, so the write data is forwarded instead.
        if ((next_state == ST_DATA) && !next_is_write) begin
            if ((state == ST_DATA) && is_write && (idx == next_idx)) begin
                next_rd_buf = hwdata;
            end else begin
                next_rd_buf = mem[next_idx];
            end
        end
    end

    assign hrdata = ((state == ST_DATA) && !is_write) ? rd_buf : 32'd0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
//------------------------------------------------------------------------------
// tb_ahb_sram_slave
//
// Two slaves share one AHB-Lite bus. Slave 0 has a zero-wait 1024-word window
// at 0x0000_0000. Slave 1 has a 3-wait 256-word window at 0x1000_0000. The
// bench acts as the master. It pipelines a queue of transfers and checks each
// data phase against a transaction-level reference: word arrays, a window
// test done in wide signed arithmetic, and a fixed wait count per slave.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ahb_sram_slave;

   localparam logic [31:0] BASE0  = 32'h0000_0000;
   localparam int          DEPTH0 = 1024;
   localparam int          WAITS0 = 0;
   localparam logic [31:0] BASE1  = 32'h1000_0000;
   localparam int          DEPTH1 = 256;
   localparam int          WAITS1 = 3;

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_BUSY   = 2'b01;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;
   localparam logic [2:0] SZW       = 3'b010;
   localparam int         BUDGET    = 5000;

   // One bus transfer as the master sees it; target 2 selects no slave.
   typedef struct packed {
      logic [1:0]  target;
      logic [1:0]  trans;
      logic        wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
   } xferT;

   logic        clock = 1'b0;
   logic        hrest;
   logic        hsel0;
   logic        hsel1;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [3:0]  hprot;
   logic        hready0;
   logic        hready1;
   logic [1:0]  hresp0;
   logic [1:0]  hresp1;
   logic [31:0] hrdata0;
   logic [31:0] hrdata1;
   logic        hreadyBus;
   logic [1:0]  hrespBus;
   logic [31:0] hrdataBus;

   logic [31:0] refMem0 [DEPTH0];
   logic [31:0] refMem1 [DEPTH1];
   xferT        txq [$];
   xferT        idleX;

   int assertCount = 0;
   int failCount   = 0;

   // An idle slave drives OKAY, ready and zero data, so the bus return path
   // is a plain AND/OR of both slaves.
   assign hreadyBus = hready0 & hready1;
   assign hrespBus  = hresp0 | hresp1;
   assign hrdataBus = hrdata0 | hrdata1;

   // 100 MHz bus clock.
   always #5 clock = ~clock;

   ahb_sram_slave #(.ADDR_BASE(BASE0), .MEM_DEPTH(DEPTH0), .WAIT_CYCLES(WAITS0)) dut0 (
      .hclk(clock), .hrest(hrest), .hsel(hsel0), .htrans(htrans), .hwrite(hwrite),
      .haddr(haddr), .hwdata(hwdata), .hsize(hsize), .hburst(hburst), .hprot(hprot),
      .hready_in(hreadyBus), .hready_out(hready0), .hresp(hresp0), .hrdata(hrdata0)
   );

   ahb_sram_slave #(.ADDR_BASE(BASE1), .MEM_DEPTH(DEPTH1), .WAIT_CYCLES(WAITS1)) dut1 (
      .hclk(clock), .hrest(hrest), .hsel(hsel1), .htrans(htrans), .hwrite(hwrite),
      .haddr(haddr), .hwdata(hwdata), .hsize(hsize), .hburst(hburst), .hprot(hprot),
      .hready_in(hreadyBus), .hready_out(hready1), .hresp(hresp1), .hrdata(hrdata1)
   );

   // Every comparison in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %h, required %h", tag, observed, expected);
      end
   endtask

   function automatic xferT mk(input logic [1:0] target, input logic [1:0] trans, input logic wr,
                               input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
      xferT x;
      x.target = target;
      x.trans  = trans;
      x.wr     = wr;
      x.addr   = addr;
      x.size   = size;
      x.wdata  = wdata;
      return x;
   endfunction

   // Reference model: a transfer reaches a slave only if it is NONSEQ/SEQ
   // and selects one. It is legal when its byte offset from the base lies in
   // [0, 4*depth), it is word aligned, and it is word sized.
   function automatic logic isActive(input xferT x);
      return x.trans[1] && (x.target < 2'd2);
   endfunction

   function automatic longint offsetOf(input xferT x);
      longint base;
      base = (x.target == 2'd1) ? longint'({32'b0, BASE1}) : longint'({32'b0, BASE0});
      return longint'({32'b0, x.addr}) - base;
   endfunction

   function automatic logic isLegal(input xferT x);
      longint span;
      longint off;
      span = (x.target == 2'd1) ? longint'(DEPTH1) * 4 : longint'(DEPTH0) * 4;
      off  = offsetOf(x);
      return (off >= 0) && (off < span) && (x.addr[1:0] == 2'b00) && (x.size == SZW);
   endfunction

   function automatic int waitsOf(input xferT x);
      return (x.target == 2'd1) ? WAITS1 : WAITS0;
   endfunction

   function automatic logic [31:0] refRead(input xferT x);
      int i;
      i = int'(offsetOf(x) / 4);
      return (x.target == 2'd1) ? refMem1[i] : refMem0[i];
   endfunction

   task automatic refWrite(input xferT x);
      int i;
      i = int'(offsetOf(x) / 4);
      if (x.target == 2'd1) refMem1[i] = x.wdata;
      else                  refMem0[i] = x.wdata;
   endtask

   // Drives one address phase. A cleared valid means an idle bus.
   task automatic applyStimulus(input logic valid, input xferT x);
      if (valid) begin
         hsel0  = (x.target == 2'd0);
         hsel1  = (x.target == 2'd1);
         htrans = x.trans;
         hwrite = x.wr;
         haddr  = x.addr;
         hsize  = x.size;
      end else begin
         hsel0  = 1'b0;
         hsel1  = 1'b0;
         htrans = TR_IDLE;
         hwrite = 1'b0;
         haddr  = $urandom();
         hsize  = SZW;
      end
      hburst = 3'($urandom());
      hprot  = 4'($urandom());
   endtask

   // Pipelined master. It presents the queue head as the address phase and
   // checks the data phase of the previous transfer at the falling edge. It
   // moves both phases on after every ready cycle. Stalls are counted and
   // compared with the wait count the reference expects.
   task automatic runQueue();
      xferT dp;
      logic dpValid;
      logic rdy;
      int   stalls;
      int   cycles;
      dpValid = 1'b0;
      stalls  = 0;
      cycles  = 0;
      while ((txq.size() > 0 || dpValid) && cycles < BUDGET) begin
         cycles++;
         if (txq.size() > 0) applyStimulus(1'b1, txq[0]);
         else                applyStimulus(1'b0, idleX);
         hwdata = (dpValid && isActive(dp) && dp.wr) ? dp.wdata : $urandom();
         @(negedge clock);
         rdy = hreadyBus;
         if (dpValid) begin
            if (!rdy) stalls++;
            if (isActive(dp) && isLegal(dp)) begin
               if (!rdy) begin
                  checkOutput("waitResp", 32'(hrespBus), 32'h0);
                  checkOutput("waitRdata", hrdataBus, 32'h0);
               end else begin
                  checkOutput("dataWaits", 32'(stalls), 32'(waitsOf(dp)));
                  checkOutput("dataResp", 32'(hrespBus), 32'h0);
                  if (dp.wr) begin
                     checkOutput("writeRdata", hrdataBus, 32'h0);
                     refWrite(dp);
                  end else begin
                     checkOutput("readData", hrdataBus, refRead(dp));
                  end
               end
            end else if (isActive(dp)) begin
               checkOutput("errResp", 32'(hrespBus), 32'h1);
               checkOutput("errRdata", hrdataBus, 32'h0);
               if (rdy) checkOutput("errWaits", 32'(stalls), 32'h1);
            end else begin
               checkOutput("idleReady", 32'(rdy), 32'h1);
               checkOutput("idleResp", 32'(hrespBus), 32'h0);
               checkOutput("idleRdata", hrdataBus, 32'h0);
            end
            if (stalls > 20) begin
               checkOutput("stallBound", 32'(stalls), 32'(waitsOf(dp)));
               txq.delete();
               dpValid = 1'b0;
               rdy     = 1'b0;
            end
         end
         @(posedge clock);
         #1;
         if (rdy) begin
            if (txq.size() > 0) begin
               dp      = txq.pop_front();
               dpValid = 1'b1;
            end else begin
               dpValid = 1'b0;
            end
            stalls = 0;
         end
      end
      if (cycles >= BUDGET) begin
         checkOutput("runBudget", 32'(cycles), 32'(BUDGET - 1));
         txq.delete();
      end
      applyStimulus(1'b0, idleX);
   endtask

   // Safety net in case something stalls outside the bounded loops.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Main sequence: reset, preload, directed cases from the plan, mid-wait
   // reset, then a randomized mixed stream.
   initial begin
      idleX  = '0;
      hrest  = 1'b1;
      hwdata = 32'd0;
      applyStimulus(1'b0, idleX);
      repeat (3) @(posedge clock);
      #1;
      hrest = 1'b0;
      @(negedge clock);
      checkOutput("rstReady", 32'(hreadyBus), 32'h1);
      checkOutput("rstResp", 32'(hrespBus), 32'h0);
      checkOutput("rstRdata", hrdataBus, 32'h0);
      @(posedge clock);
      #1;

      // Preload the first 16 words of each window.
      for (int i = 0; i < 16; i++) begin
         txq.push_back(mk(2'd0, TR_NONSEQ, 1'b1, BASE0 + 32'(4 * i), SZW, $urandom()));
         txq.push_back(mk(2'd1, TR_NONSEQ, 1'b1, BASE1 + 32'(4 * i), SZW, $urandom()));
      end
      runQueue();

      // Zero-wait write, idle gap, then read back.
      txq.push_back(mk(2'd0, TR_NONSEQ, 1'b1, 32'h10, SZW, 32'hDEAD_BEEF));
      txq.push_back(mk(2'd0, TR_IDLE, 1'b0, 32'h0, SZW, 32'h0));
      txq.push_back(mk(2'd0, TR_NONSEQ, 1'b0, 32'h10, SZW, 32'h0));
      runQueue();

      // Back-to-back write and read of the same word: read must see new data.
      txq.push_back(mk(2'd0, TR_NONSEQ, 1'b1, 32'h20, SZW, 32'h1234_5678));
      txq.push_back(mk(2'd0, TR_NONSEQ, 1'b0, 32'h20, SZW, 32'h0));
      runQueue();

      // Three-wait slave reading a known word.
      txq.push_back(mk(2'd1, TR_NONSEQ, 1'b1, BASE1, SZW, 32'hA5A5_A5A5));
      txq.push_back(mk(2'd1, TR_IDLE, 1'b0, 32'h0, SZW, 32'h0));
      txq.push_back(mk(2'd1, TR_NONSEQ, 1'b0, BASE1, SZW, 32'h0));
      runQueue();

      // Error responses: one past the window end, and a byte-sized write.
      txq.push_back(mk(2'd0, TR_NONSEQ, 1'b0, BASE0 + 32'(4 * DEPTH0), SZW, 32'h0));
      txq.push_back(mk(2'd0, TR_NONSEQ, 1'b1, 32'h4, 3'b000, 32'hBAD0_BAD0));
      txq.push_back(mk(2'd0, TR_NONSEQ, 1'b0, 32'h4, SZW, 32'h0));
      txq.push_back(mk(2'd1, TR_NONSEQ, 1'b0, BASE1 - 32'd4, SZW, 32'h0));
      runQueue();

      // BUSY and a deselected NONSEQ write must leave memory unchanged.
      txq.push_back(mk(2'd0, TR_BUSY, 1'b1, 32'h4, SZW, 32'h0F0F_0F0F));
      txq.push_back(mk(2'd2, TR_NONSEQ, 1'b1, 32'h4, SZW, 32'hF0F0_F0F0));
      txq.push_back(mk(2'd0, TR_NONSEQ, 1'b0, 32'h4, SZW, 32'h0));
      runQueue();

      // Reset in the second wait cycle of a write aborts it.
      applyStimulus(1'b1, mk(2'd1, TR_NONSEQ, 1'b1, BASE1 + 32'h8, SZW, 32'hFFFF_0000));
      @(negedge clock);
      checkOutput("abortAddrReady", 32'(hreadyBus), 32'h1);
      @(posedge clock);
      #1;
      applyStimulus(1'b0, idleX);
      hwdata = 32'hFFFF_0000;
      @(negedge clock);
      checkOutput("abortWait1Ready", 32'(hreadyBus), 32'h0);
      @(posedge clock);
      #1;
      hrest = 1'b1;
      @(negedge clock);
      checkOutput("abortWait2Ready", 32'(hreadyBus), 32'h0);
      @(posedge clock);
      #1;
      hrest = 1'b0;
      @(negedge clock);
      checkOutput("abortReady", 32'(hreadyBus), 32'h1);
      checkOutput("abortResp", 32'(hrespBus), 32'h0);
      checkOutput("abortRdata", hrdataBus, 32'h0);
      @(posedge clock);
      #1;
      repeat (4) begin
         @(posedge clock);
         #1;
      end
      txq.push_back(mk(2'd1, TR_NONSEQ, 1'b0, BASE1 + 32'h8, SZW, 32'h0));
      runQueue();

      // Randomized stream mixing both slaves, idle/busy beats and illegal
      // accesses.
      for (int n = 0; n < 400; n++) begin
         logic [1:0]  tgt;
         logic [1:0]  trans;
         logic [31:0] base;
         logic [31:0] addr;
         logic [2:0]  size;
         int          depth;
         int          pick;
         tgt   = 2'($urandom_range(0, 1));
         base  = (tgt == 2'd1) ? BASE1 : BASE0;
         depth = (tgt == 2'd1) ? DEPTH1 : DEPTH0;
         addr  = base + 32'(4 * $urandom_range(0, 15));
         trans = ($urandom_range(0, 1) == 0) ? TR_NONSEQ : TR_SEQ;
         size  = SZW;
         pick  = int'($urandom_range(0, 24));
         case (pick)
            0: addr = base + 32'(4 * depth) + 32'(4 * $urandom_range(0, 7));
            1: addr = addr + 32'($urandom_range(1, 3));
            2: size = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b011;
            3: trans = TR_BUSY;
            4: trans = TR_IDLE;
            5: tgt = 2'd2;
            6: addr = base - 32'd4;
            default: ;
         endcase
         txq.push_back(mk(tgt, trans, 1'($urandom_range(0, 1)), addr, size, $urandom()));
      end
      runQueue();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
